regfile_read_stage: RTL and testbench
=====================================

# regfile_read_stage

Read side of the 64-bit ARM register file: 32 × 64-bit architectural registers with one write port and two registered read ports feeding the decode/execute pipeline register. Reads carry a valid/ready handshake so downstream stalls hold operands. Same-cycle write-to-read bypass and stall-time operand refresh prevent stale values. X31 always reads as zero (XZR), and writes to X31 are discarded.

## Interface
- WIDTH, 64, register data width
- NREG, 32, number of architectural registers
- AW, 5, register address width
- ZR_IDX, 31, zero-register index

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low (0 = reset)
- rd_valid_in  input  1  read request valid
- rd_ready_out  output  1  stage can accept a request
- ra1, ra2  input  AW  read addresses
- wr_en  input  1  write strobe
- wa  input  AW  write address
- wd  input  WIDTH  write data
- rd_valid_out  output  1  operands valid
- rd_ready_in  input  1  downstream accepts operands
- rd1_out, rd2_out  output  WIDTH  read operands
- ra1_q, ra2_q  output  AW  addresses of held operands

## Operation
- Reset (reset==0 at posedge): all NREG registers ← 0; rd_valid_out ← 0; rd1_out, rd2_out ← 0; ra1_q, ra2_q ← 0. Writes are ignored during the reset cycle.
- Write: if wr_en && wa != ZR_IDX, reg[wa] ← wd at posedge. Writes to ZR_IDX are dropped.
- rd_ready_out = !rd_valid_out || rd_ready_in (combinational).
- Accept = rd_valid_in && rd_ready_out. On accept, at the posedge:
  - rd_valid_out ← 1; raN_q ← raN.
  - rdN_out ← 0 if raN == ZR_IDX.
  - Otherwise rdN_out ← wd if wr_en && wa == raN (bypass, write-first).
  - Otherwise rdN_out ← reg[raN].
- Drain: rd_valid_out && rd_ready_in && !accept → rd_valid_out ← 0; the data outputs keep their last value.
- Hold: rd_valid_out && !rd_ready_in → all outputs hold, except refresh:
  - If wr_en && wa == raN_q && wa != ZR_IDX, then rdN_out ← wd.
  - Both ports refresh independently. If ra1_q == ra2_q, both refresh.
- Both read addresses may be equal. Each port resolves independently.
- A write and a read to the same register in one cycle always returns the new data. There is no read-old mode.

## Timing
- Read latency: 1 cycle from accept to rd_valid_out.
- Throughput: 1 request/cycle while rd_ready_in == 1.
- The write is visible in the array 1 cycle after the wr_en edge. It is visible to a same-edge read through the bypass.
- Reset asserted mid-hold clears rd_valid_out at that edge. The in-flight operands are lost, and the stage is ready in the next cycle.
- No combinational path from rd_ready_in to rdN_out. Only the path rd_ready_in → rd_ready_out is combinational.

## Structure
- Shared package `arm_cpu_pkg` holds: WIDTH, NREG, AW, ZR_IDX, and a `reg_addr_t` typedef (logic [AW-1:0]).
- Storage uses the existing per-bit register cell with write enable, one per register, selected by a 5→32 write decoder.
- Sub-module `regfile_read_port`: one instance per read port. It contains the read mux, ZR forcing, bypass compare, hold/refresh output flop, and address capture. Handshake control lives in the top module.

## Test plan
- Reset: drive reset=0 for 2 cycles with wr_en=1, wa=3, wd=0xFF → all outputs 0, rd_valid_out=0. A later read of X3 returns 0.
- Write/read: write X5=0x0123_4567_89AB_CDEF, then in the next cycle read ra1=5, ra2=31 → one cycle later rd1_out=0x0123456789ABCDEF, rd2_out=0, rd_valid_out=1.
- Bypass: in the same cycle set wr_en=1, wa=7, wd=64, and accept ra1=ra2=7 → next cycle rd1_out=rd2_out=64. Write X31=0xDEAD, then read X31 → 0.
- Stall refresh: accept ra1=2 (X2=1) with rd_ready_in=0, then write X2=128 during the hold → rd1_out becomes 128 one cycle later. rd_ready_out=0 throughout the hold, and rd_valid_out stays 1.
- Back-to-back: with rd_ready_in=1, issue reads of X1, X2, X3 on consecutive cycles → outputs follow one per cycle with no bubbles. Drop rd_valid_in → rd_valid_out falls one cycle later.
- Reset mid-hold: while stalled with valid operands, pulse reset=0 for one cycle → rd_valid_out=0 and rd_ready_out=1 on the next cycle.

Source files
------------

// File: rtl/arm_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_cpu_pkg
// Description : Shared constants and types for the 64-bit ARM register file.
//               WIDTH  - register data width
//               NREG   - number of architectural registers
//               AW     - register address width
//               ZR_IDX - index of the zero register (XZR)
// Revision    : 1.0 - initial release
// ============================================================================
package arm_cpu_pkg;

    localparam int WIDTH  = 64;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int ZR_IDX = 31;

    typedef logic [AW-1:0] reg_addr_t;

    // Zero-register index at address width, so compares stay width-matched.
    localparam reg_addr_t ZR_ADDR = reg_addr_t'(ZR_IDX);

endpackage : arm_cpu_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : One registered read port of the register file. Holds the
//               read mux, XZR forcing, write-first bypass, the hold/refresh
//               output flop and the captured read address.
// Ports       : clk      - rising-edge clock
//               reset    - synchronous active-low reset
//               i_accept - new request accepted this cycle
//               i_hold   - operands valid and stalled downstream
//               i_ra     - read address for a new request
//               i_regs   - current architectural register contents
//               i_wr_en  - write strobe
//               i_wa     - write address
//               i_wd     - write data
//               o_rd     - registered read operand
//               o_ra_q   - address of the held operand
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import arm_cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_accept,
    input  logic             i_hold,
    input  logic [AW-1:0]    i_ra,
    input  logic [WIDTH-1:0] i_regs [NREG],
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wa,
    input  logic [WIDTH-1:0] i_wd,
    output logic [WIDTH-1:0] o_rd,
    output logic [AW-1:0]    o_ra_q
);

    logic [WIDTH-1:0] rd_d, rd_q;
    logic [AW-1:0]    ra_d, ra_q;

    always_comb begin
        rd_d = rd_q;
        ra_d = ra_q;
        if (i_accept) begin
            ra_d = i_ra;
            if (i_ra == ZR_ADDR) begin
                rd_d = '0;
            end else if (i_wr_en && (i_wa == i_ra)) begin
                // Write-first: same-edge write wins over the array contents.
                rd_d = i_wd;
            end else begin
                rd_d = i_regs[i_ra];
            end
        end else if (i_hold) begin
            // Keep a stalled operand coherent with writes to its register.
            if (i_wr_en && (i_wa == ra_q) && (i_wa != ZR_ADDR)) begin
                rd_d = i_wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q <= '0;
            ra_q <= '0;
        end else begin
            rd_q <= rd_d;
            ra_q <= ra_d;
        end
    end

    assign o_rd   = rd_q;
    assign o_ra_q = ra_q;

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_stage
// Description : Read side of the 64-bit ARM register file. 32 x 64-bit
//               registers, one write port, two registered read ports with a
//               valid/ready handshake. XZR reads as zero, writes to it drop.
// Ports       : clk            - rising-edge clock
//               reset          - synchronous active-low reset
//               rd_valid_in    - read request valid
//               rd_ready_out   - stage can accept a request
//               ra1, ra2       - read addresses
//               wr_en, wa, wd  - write port
//               rd_valid_out   - operands valid
//               rd_ready_in    - downstream accepts operands
//               rd1_out,rd2_out- read operands
//               ra1_q, ra2_q   - addresses of held operands
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_stage
    import arm_cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_valid_in,
    output logic             rd_ready_out,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    output logic             rd_valid_out,
    input  logic             rd_ready_in,
    output logic [WIDTH-1:0] rd1_out,
    output logic [WIDTH-1:0] rd2_out,
    output logic [AW-1:0]    ra1_q,
    output logic [AW-1:0]    ra2_q
);

    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] regs_q [NREG];
    logic [NREG-1:0]  w_wr_dec;
    logic             valid_d, valid_q;
    logic             w_accept;
    logic             w_hold;

    // ------------------------------------------------------------------
    // Storage: one-hot write decode; XZR never decodes so it stays zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_dec = '0;
        if (wr_en && (wa != ZR_ADDR)) begin
            w_wr_dec[wa] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = w_wr_dec[i] ? wd : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign rd_ready_out = !valid_q || rd_ready_in;
    assign w_accept     = rd_valid_in && rd_ready_out;
    assign w_hold       = valid_q && !rd_ready_in;

    always_comb begin
        valid_d = valid_q;
        if (w_accept) begin
            valid_d = 1'b1;
        end else if (rd_ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rd_valid_out = valid_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    regfile_read_port u_port1 (
        .clk      (clk),
        .reset    (reset),
        .i_accept (w_accept),
        .i_hold   (w_hold),
        .i_ra     (ra1),
        .i_regs   (regs_q),
        .i_wr_en  (wr_en),
        .i_wa     (wa),
        .i_wd     (wd),
        .o_rd     (rd1_out),
        .o_ra_q   (ra1_q)
    );

    regfile_read_port u_port2 (
        .clk      (clk),
        .reset    (reset),
        .i_accept (w_accept),
        .i_hold   (w_hold),
        .i_ra     (ra2),
        .i_regs   (regs_q),
        .i_wr_en  (wr_en),
        .i_wa     (wa),
        .i_wd     (wd),
        .o_rd     (rd2_out),
        .o_ra_q   (ra2_q)
    );

endmodule : regfile_read_stage
`default_nettype wire

// File: tb/tb_regfile_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_read_stage
// Description : Self-checking bench for regfile_read_stage using a table of
//               directed vectors plus hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_read_stage;

    logic        clk;
    logic        reset;
    logic        rd_valid_in;
    logic        rd_ready_out;
    logic [4:0]  ra1, ra2;
    logic        wr_en;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        rd_valid_out;
    logic        rd_ready_in;
    logic [63:0] rd1_out, rd2_out;
    logic [4:0]  ra1_q, ra2_q;

    int checks;
    int failures;

    typedef struct {
        logic        vin;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        we;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic        rin;
        logic        e_valid;
        logic        e_ready;
        logic [63:0] e_rd1;
        logic [63:0] e_rd2;
        logic [4:0]  e_q1;
        logic [4:0]  e_q2;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    regfile_read_stage dut (
        .clk          (clk),
        .reset        (reset),
        .rd_valid_in  (rd_valid_in),
        .rd_ready_out (rd_ready_out),
        .ra1          (ra1),
        .ra2          (ra2),
        .wr_en        (wr_en),
        .wa           (wa),
        .wd           (wd),
        .rd_valid_out (rd_valid_out),
        .rd_ready_in  (rd_ready_in),
        .rd1_out      (rd1_out),
        .rd2_out      (rd2_out),
        .ra1_q        (ra1_q),
        .ra2_q        (ra2_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic vin, logic [4:0] a1, logic [4:0] a2,
                                logic we, logic [4:0] waddr, logic [63:0] wdata,
                                logic rin, logic e_valid, logic e_ready,
                                logic [63:0] e_rd1, logic [63:0] e_rd2,
                                logic [4:0] e_q1, logic [4:0] e_q2);
        vec_t v;
        v.vin = vin;  v.a1 = a1;  v.a2 = a2;
        v.we = we;    v.waddr = waddr;  v.wdata = wdata;  v.rin = rin;
        v.e_valid = e_valid;  v.e_ready = e_ready;
        v.e_rd1 = e_rd1;  v.e_rd2 = e_rd2;  v.e_q1 = e_q1;  v.e_q2 = e_q2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rd_valid_in = v.vin;
        ra1         = v.a1;
        ra2         = v.a2;
        wr_en       = v.we;
        wa          = v.waddr;
        wd          = v.wdata;
        rd_ready_in = v.rin;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, ".valid"}, 64'(rd_valid_out), 64'(v.e_valid));
        chk({tag, ".ready"}, 64'(rd_ready_out), 64'(v.e_ready));
        chk({tag, ".rd1"},   rd1_out,           v.e_rd1);
        chk({tag, ".rd2"},   rd2_out,           v.e_rd2);
        chk({tag, ".ra1_q"}, 64'(ra1_q),        64'(v.e_q1));
        chk({tag, ".ra2_q"}, 64'(ra2_q),        64'(v.e_q2));
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check_all(tag, v);
    endtask

    localparam logic [63:0] C_X5 = 64'h0123_4567_89AB_CDEF;

    initial begin
        checks   = 0;
        failures = 0;

        // Fields: vin a1 a2 we wa wd rin | valid ready rd1 rd2 q1 q2
        vecs[0]  = mk(0,  0,  0, 1,  5, C_X5,     1, 0, 1, 64'h0,  64'h0,  0,  0);
        vecs[1]  = mk(1,  5, 31, 0,  0, 64'h0,    1, 1, 1, C_X5,   64'h0,  5, 31);
        vecs[2]  = mk(1,  3,  3, 0,  0, 64'h0,    1, 1, 1, 64'h0,  64'h0,  3,  3);
        vecs[3]  = mk(1,  7,  7, 1,  7, 64'd64,   1, 1, 1, 64'd64, 64'd64, 7,  7);
        vecs[4]  = mk(0,  0,  0, 1, 31, 64'hDEAD, 1, 0, 1, 64'd64, 64'd64, 7,  7);
        vecs[5]  = mk(1, 31,  7, 0,  0, 64'h0,    1, 1, 1, 64'h0,  64'd64, 31, 7);
        vecs[6]  = mk(0,  0,  0, 1,  2, 64'd1,    1, 0, 1, 64'h0,  64'd64, 31, 7);
        // Accept with downstream stalled, then refresh during the hold.
        vecs[7]  = mk(1,  2,  5, 0,  0, 64'h0,    0, 1, 0, 64'd1,  C_X5,   2,  5);
        vecs[8]  = mk(1,  1,  1, 1,  2, 64'd128,  0, 1, 0, 64'd128, C_X5,  2,  5);
        vecs[9]  = mk(0,  0,  0, 1,  5, 64'hAA,   0, 1, 0, 64'd128, 64'hAA, 2, 5);
        vecs[10] = mk(0,  0,  0, 1,  1, 64'h11,   0, 1, 0, 64'd128, 64'hAA, 2, 5);
        vecs[11] = mk(0,  0,  0, 1,  3, 64'h33,   0, 1, 0, 64'd128, 64'hAA, 2, 5);
        // Back-to-back reads with no bubbles, then drop the request.
        vecs[12] = mk(1,  1,  2, 0,  0, 64'h0,    1, 1, 1, 64'h11, 64'd128, 1, 2);
        vecs[13] = mk(1,  2,  3, 0,  0, 64'h0,    1, 1, 1, 64'd128, 64'h33, 2, 3);
        vecs[14] = mk(1,  3,  1, 0,  0, 64'h0,    1, 1, 1, 64'h33, 64'h11,  3, 1);
        vecs[15] = mk(0,  0,  0, 0,  0, 64'h0,    1, 0, 1, 64'h33, 64'h11,  3, 1);

        // Reset for two cycles with a write to X3 pending; it must be dropped.
        reset = 1'b0;
        drive(mk(0, 0, 0, 1, 3, 64'hFF, 1, 0, 0, 64'h0, 64'h0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", mk(0, 0, 0, 0, 0, 64'h0, 1, 0, 1, 64'h0, 64'h0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Stalled valid operands, then a one-cycle reset pulse.
        step("stall5", mk(1, 5, 5, 0, 0, 64'h0, 0, 1, 0, 64'hAA, 64'hAA, 5, 5));
        @(negedge clk);
        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0, 0));
        @(posedge clk);
        #1;
        check_all("mid_reset", mk(0, 0, 0, 0, 0, 64'h0, 0, 0, 1, 64'h0, 64'h0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        // Registers were cleared by the reset, so X5 now reads zero.
        step("post_reset", mk(1, 5, 1, 0, 0, 64'h0, 1, 1, 1, 64'h0, 64'h0, 5, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_read_stage
`default_nettype wire
